// File: rtl/unified_mem_arbiter.sv
// Shares one single-port SRAM between fetch and data ports; grant is combinational, read data returns 1 cycle after grant.
// Backpressure: a losing or flushed requester sees ready=0 and holds its request; a starvation limiter guarantees fetch progress.
module unified_mem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      i_req,
    input  logic [ADDRESS_BITS-1:0]   i_addr,
    output logic                      i_ready,
    output logic                      i_valid,
    output logic [DATA_WIDTH-1:0]     i_rdata,
    input  logic                      flush,
    input  logic                      d_req,
    input  logic                      d_we,
    input  logic [ADDRESS_BITS-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]     d_wdata,
    input  logic [DATA_WIDTH/8-1:0]   d_byte_en,
    output logic                      d_ready,
    output logic                      d_valid,
    output logic [DATA_WIDTH-1:0]     d_rdata,
    output logic                      m_en,
    output logic                      m_we,
    output logic [ADDRESS_BITS-1:0]   m_addr,
    output logic [DATA_WIDTH-1:0]     m_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_byte_en,
    input  logic [DATA_WIDTH-1:0]     m_rdata,
    output logic [31:0]               conflict_cycles
);

    localparam int         BE_W      = DATA_WIDTH / 8;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {OWN_NONE, OWN_INST, OWN_DATA} owner_t;

    typedef struct packed {
        logic                    en;
        logic                    we;
        logic [ADDRESS_BITS-1:0] addr;
        logic [DATA_WIDTH-1:0]   wdata;
        logic [BE_W-1:0]         byte_en;
    } mreq_t;

    owner_t     owner_q, owner_d;
    logic [3:0] starve_q;
    logic       fetch_win, data_win;
    mreq_t      mreq;

    // Gating by reset keeps every grant and the SRAM enable low while reset is held.
    always_comb begin
        fetch_win = reset && i_req && !flush && (!d_req || (starve_q >= STARVE_LIM));
        data_win  = reset && d_req && !fetch_win;
    end

    assign i_ready = fetch_win;
    assign d_ready = data_win;

    always_comb begin
        mreq    = '0;
        owner_d = OWN_NONE;
        if (fetch_win) begin
            mreq.en      = 1'b1;
            mreq.addr    = i_addr;
            mreq.byte_en = '1;
            owner_d      = OWN_INST;
        end else if (data_win) begin
            mreq.en      = 1'b1;
            mreq.we      = d_we;
            mreq.addr    = d_addr;
            mreq.wdata   = d_wdata;
            mreq.byte_en = d_byte_en;
            owner_d      = OWN_DATA;
        end
    end

    assign m_en      = mreq.en;
    assign m_we      = mreq.we;
    assign m_addr    = mreq.addr;
    assign m_wdata   = mreq.wdata;
    assign m_byte_en = mreq.byte_en;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) owner_q <= OWN_NONE;
        else        owner_q <= owner_d;
    end

    // Flush freezes the counter, even over the clear that i_req=0 would otherwise cause.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                     starve_q <= 4'd0;
        else if (flush)                 starve_q <= starve_q;
        else if (!i_req || fetch_win)   starve_q <= 4'd0;
        else if (starve_q != 4'hF)      starve_q <= starve_q + 4'd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            conflict_cycles <= '0;
        else if (i_req && d_req && (conflict_cycles != 32'hFFFF_FFFF))
            conflict_cycles <= conflict_cycles + 32'd1;
    end

    assign i_valid = (owner_q == OWN_INST) && !flush;
    assign i_rdata = m_rdata;
    assign d_valid = (owner_q == OWN_DATA);
    assign d_rdata = m_rdata;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed stimulus for the unified SRAM arbiter with a queue scoreboard and a behavioural 1-cycle SRAM.
module tb_unified_mem_arbiter;

    logic        clock, reset;
    logic        i_req, i_ready, i_valid, flush;
    logic [19:0] i_addr, d_addr, m_addr;
    logic [31:0] i_rdata, d_wdata, d_rdata, m_wdata, m_rdata, conflict_cycles;
    logic        d_req, d_we, d_ready, d_valid, m_en, m_we;
    logic [3:0]  d_byte_en, m_byte_en;

    typedef struct {
        logic        check_data;
        logic [31:0] data;
    } dexp_t;

    logic [31:0] exp_i[$];
    dexp_t       exp_d[$];
    logic [31:0] mem [0:255];
    logic [31:0] wtmp;
    int          errors = 0;
    int          checks = 0;

    unified_mem_arbiter #(.DATA_WIDTH(32), .ADDRESS_BITS(20), .STARVE_LIMIT(4)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_valid(i_valid), .i_rdata(i_rdata),
        .flush(flush),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_byte_en(d_byte_en),
        .d_ready(d_ready), .d_valid(d_valid), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_byte_en(m_byte_en),
        .m_rdata(m_rdata), .conflict_cycles(conflict_cycles)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) begin
        if (m_en) begin
            if (m_we) begin
                wtmp = mem[m_addr[9:2]];
                for (int b = 0; b < 4; b++)
                    if (m_byte_en[b]) wtmp[b*8 +: 8] = m_wdata[b*8 +: 8];
                mem[m_addr[9:2]] <= wtmp;
            end else begin
                m_rdata <= mem[m_addr[9:2]];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: every response the DUT presents must match the head of its queue.
    always @(negedge clock) begin
        dexp_t de;
        if (i_valid !== 1'b0) begin
            if (exp_i.size() == 0) begin
                checks++; errors++;
                $display("FAIL i_valid_unexpected: got %b expected 0 at %0t", i_valid, $time);
            end else begin
                chk("i_rdata", i_rdata, exp_i.pop_front());
            end
        end
        if (d_valid !== 1'b0) begin
            if (exp_d.size() == 0) begin
                checks++; errors++;
                $display("FAIL d_valid_unexpected: got %b expected 0 at %0t", d_valid, $time);
            end else begin
                de = exp_d.pop_front();
                if (de.check_data) chk("d_rdata", d_rdata, de.data);
                else               checks++;
            end
        end
    end

    task automatic step(input logic ei, input logic ed, input string tag);
        @(negedge clock);
        chk({tag, "_i_ready"}, 32'(i_ready), 32'(ei));
        chk({tag, "_d_ready"}, 32'(d_ready), 32'(ed));
        @(posedge clock);
        #1;
    endtask

    function automatic dexp_t dx(input logic c, input logic [31:0] v);
        dexp_t r;
        r.check_data = c;
        r.data       = v;
        return r;
    endfunction

    initial begin
        reset = 1'b0; flush = 1'b0;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_byte_en = 4'hF;
        m_rdata = '0;
        for (int k = 0; k < 256; k++) mem[k] = 32'h0;
        mem[0]  = 32'h13;
        mem[1]  = 32'h93;
        mem[2]  = 32'h113;
        mem[17] = 32'h1122_3344;

        // Reset held with both ports requesting: nothing may be granted.
        i_req = 1'b1; d_req = 1'b1;
        @(negedge clock);
        chk("rst_i_ready", 32'(i_ready), 32'd0);
        chk("rst_d_ready", 32'(d_ready), 32'd0);
        chk("rst_m_en", 32'(m_en), 32'd0);
        chk("rst_m_we", 32'(m_we), 32'd0);
        chk("rst_i_valid", 32'(i_valid), 32'd0);
        chk("rst_d_valid", 32'(d_valid), 32'd0);
        chk("rst_conflict", conflict_cycles, 32'd0);
        @(posedge clock); #1;
        i_req = 1'b0; d_req = 1'b0; reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            chk("idle_m_en", 32'(m_en), 32'd0);
            @(posedge clock); #1;
        end
        chk("idle_conflict", conflict_cycles, 32'd0);

        // Fetch-only stream.
        i_req = 1'b1;
        i_addr = 20'h0; step(1'b1, 1'b0, "fs0"); exp_i.push_back(32'h13);
        i_addr = 20'h4; step(1'b1, 1'b0, "fs1"); exp_i.push_back(32'h93);
        i_addr = 20'h8; step(1'b1, 1'b0, "fs2"); exp_i.push_back(32'h113);
        i_req = 1'b0;   step(1'b0, 1'b0, "fs_end");

        // Continuous conflict: four data grants then one fetch grant.
        i_req = 1'b1; i_addr = 20'h4; d_req = 1'b1; d_we = 1'b0; d_addr = 20'h8;
        for (int c = 0; c < 10; c++) begin
            if (c % 5 == 4) begin
                step(1'b1, 1'b0, "starve_f");
                exp_i.push_back(32'h93);
            end else begin
                step(1'b0, 1'b1, "starve_d");
                exp_d.push_back(dx(1'b1, 32'h113));
            end
        end
        chk("conflict_10", conflict_cycles, 32'd10);
        i_req = 1'b0; d_req = 1'b0; step(1'b0, 1'b0, "starve_end");

        // Same-address write and fetch: write first, fetch sees new data.
        i_req = 1'b1; i_addr = 20'h40;
        d_req = 1'b1; d_we = 1'b1; d_addr = 20'h40; d_wdata = 32'hDEAD_BEEF; d_byte_en = 4'hF;
        step(1'b0, 1'b1, "raw_w"); exp_d.push_back(dx(1'b0, 32'h0));
        d_req = 1'b0; d_we = 1'b0;
        step(1'b1, 1'b0, "raw_f"); exp_i.push_back(32'hDEAD_BEEF);
        i_req = 1'b0;
        chk("conflict_11", conflict_cycles, 32'd11);

        // Partial byte-enable write, then read back.
        d_req = 1'b1; d_we = 1'b1; d_addr = 20'h44; d_wdata = 32'h0000_CAFE; d_byte_en = 4'b0011;
        step(1'b0, 1'b1, "be_w"); exp_d.push_back(dx(1'b0, 32'h0));
        d_we = 1'b0; d_byte_en = 4'hF;
        step(1'b0, 1'b1, "be_r"); exp_d.push_back(dx(1'b1, 32'h1122_CAFE));
        d_req = 1'b0; step(1'b0, 1'b0, "be_end");

        // Flush: starve counter frozen at 3, then fetch response killed.
        i_req = 1'b1; i_addr = 20'h0; d_req = 1'b1; d_addr = 20'h8;
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b1, "fl_pre");
            exp_d.push_back(dx(1'b1, 32'h113));
        end
        flush = 1'b1;
        step(1'b0, 1'b1, "fl_both"); exp_d.push_back(dx(1'b1, 32'h113));
        d_req = 1'b0; step(1'b0, 1'b0, "fl_ionly");
        i_req = 1'b0; step(1'b0, 1'b0, "fl_noreq");
        flush = 1'b0; i_req = 1'b1; d_req = 1'b1;
        step(1'b0, 1'b1, "fl_post_d"); exp_d.push_back(dx(1'b1, 32'h113));
        step(1'b1, 1'b0, "fl_post_f");
        flush = 1'b1; d_req = 1'b0;
        step(1'b0, 1'b0, "fl_kill");
        flush = 1'b0; i_req = 1'b0;
        step(1'b0, 1'b0, "fl_end");
        chk("conflict_17", conflict_cycles, 32'd17);

        // Reset right after a data read grant discards the response.
        d_req = 1'b1; d_addr = 20'h8;
        step(1'b0, 1'b1, "rst_inflight");
        reset = 1'b0; d_req = 1'b0;
        @(negedge clock);
        chk("inflight_d_valid", 32'(d_valid), 32'd0);
        chk("inflight_conflict", conflict_cycles, 32'd0);
        chk("inflight_m_en", 32'(m_en), 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        for (int c = 0; c < 3; c++) step(1'b0, 1'b0, "post_rst_idle");
        i_req = 1'b1; i_addr = 20'h8;
        step(1'b1, 1'b0, "post_rst_f"); exp_i.push_back(32'h113);
        i_req = 1'b0;
        step(1'b0, 1'b0, "post_rst_end");
        step(1'b0, 1'b0, "post_rst_end2");
        chk("post_rst_conflict", conflict_cycles, 32'd0);

        chk("exp_i_drained", 32'(exp_i.size()), 32'd0);
        chk("exp_d_drained", 32'(exp_d.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Arbitrates the core's single-port unified SRAM between the instruction-fetch port and the data-memory port of the 5-stage pipeline.
- Grants at most one access per cycle and routes each 1-cycle-latency read response back to the requester that issued it.
- Guarantees forward progress for fetch with a starvation limiter.
- Drives a conflict counter for performance reporting.

Parameters:
- DATA_WIDTH, 32, word width of all data buses.
- ADDRESS_BITS, 20, address width of all address buses.
- STARVE_LIMIT, 4, consecutive denied fetch cycles after which fetch wins the next conflict; legal range 1..15.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch read request.
- i_addr  in  ADDRESS_BITS  fetch address.
- i_ready  out  1  fetch request accepted this cycle.
- i_valid  out  1  fetch read data valid.
- i_rdata  out  DATA_WIDTH  fetch read data.
- flush  in  1  pipeline flush; kills fetch traffic as defined below.
- d_req  in  1  data request.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDRESS_BITS  data address.
- d_wdata  in  DATA_WIDTH  write data.
- d_byte_en  in  DATA_WIDTH/8  write byte enables.
- d_ready  out  1  data request accepted this cycle.
- d_valid  out  1  data response (read data or write ack).
- d_rdata  out  DATA_WIDTH  data read data.
- m_en  out  1  SRAM access enable.
- m_we  out  1  SRAM write enable.
- m_addr  out  ADDRESS_BITS  SRAM address.
- m_wdata  out  DATA_WIDTH  SRAM write data.
- m_byte_en  out  DATA_WIDTH/8  SRAM byte enables.
- m_rdata  in  DATA_WIDTH  SRAM read data; valid exactly 1 cycle after m_en with m_we=0.
- conflict_cycles  out  32  count of cycles in which both ports requested.

Behaviour:
- Reset (reset=0, asynchronous):
  - i_valid=0, d_valid=0, starve counter=0, owner register=NONE, conflict_cycles=0.
  - m_en/m_we/i_ready/d_ready are combinational and read 0 while reset is asserted.
  - An access in flight when reset asserts is discarded; no valid is ever produced for it after release.
- Handshake: a request is accepted in any cycle where req && ready. Requesters hold req, addr and data stable until accepted. Back-to-back acceptance every cycle is legal.
- Arbitration (combinational, same cycle):
  - Only i_req: i_ready=1, unless flush=1.
  - Only d_req: d_ready=1.
  - Both requesting and starve counter < STARVE_LIMIT: data wins.
  - Both requesting and starve counter >= STARVE_LIMIT: fetch wins, unless flush=1, in which case data wins.
  - flush=1 forces i_ready=0 in every case.
- SRAM drive: the winner's signals go to m_*, with m_en=1. Fetch grants drive m_we=0 and m_byte_en=all ones. No grant gives m_en=0, m_we=0.
- Response routing:
  - The owner register (NONE/INST/DATA) captures the granted port each edge.
  - The cycle after a fetch grant: i_valid=1, i_rdata=m_rdata.
  - The cycle after a data grant: d_valid=1. For a read, d_rdata=m_rdata. For a write, d_valid is an ack and d_rdata is don't-care.
  - Otherwise the valid signals are 0. Response latency is exactly 1 cycle and there is never more than one response in flight.
- Flush kill: if flush=1 in the cycle a fetch response is due, i_valid=0 and the response is dropped. Data responses are never killed.
- Starve counter (4 bits, saturating at 15):
  - Increments on each cycle where i_req=1 and i_ready=0 and flush=0.
  - Clears on any fetch grant, and whenever i_req=0.
  - Holds when flush=1.
- conflict_cycles: increments on every cycle where i_req && d_req. Saturates at 32'hFFFFFFFF; no wrap.
- Simultaneous data write and fetch read of the same address: the write wins, and the fetch is granted next cycle and sees the new data (no bypass needed).

Test Plan:
- Reset then idle -> all outputs 0. Release reset, keep reqs low 10 cycles -> m_en never 1, conflict_cycles=0.
- Fetch-only stream at 0x0,0x4,0x8 with SRAM preloaded 0x13,0x93,0x113 -> i_ready=1 every cycle, i_valid on cycles 1..3 with those values in order.
- Both requesting continuously, STARVE_LIMIT=4, d_we=0 -> data granted 4 cycles, fetch 5th, then pattern repeats. conflict_cycles increments every cycle.
- Data write 0xDEADBEEF to 0x40 while fetch requests 0x40 -> write granted first, d_valid ack next cycle. Fetch granted next cycle and returns 0xDEADBEEF.
- Fetch granted at cycle N, flush=1 at N+1 -> i_valid=0 at N+1. i_ready=0 while flush=1. The starve counter neither increments nor clears during the flush.
- Assert reset=0 the cycle after a data read grant -> d_valid stays 0 through and after release. conflict_cycles=0. First post-reset grant behaves normally.
